multi_clock_divider: RTL and testbench

Parametrised multi-channel clock-enable and square-wave generator. It derives NUM_CH independent slow timebases from the system clock, for example 1 Hz display and timer ticks, buzzer tones and LED blink rates. Each channel has a divide value that is runtime-programmable, loaded glitch-free and exact (no off-by-one). All channels can be restarted together with a phase-sync input. It sits beside the top-level clocking. Its outputs are intended as clock enables (`tick`) for downstream logic, or as slow toggle outputs (`clk_out`) for pins.

---
 rtl/multi_clock_divider.sv | 125 ++++++++++++
 tb/tb_multi_clock_divider.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// multi_clock_divider
// Multi-channel clock-enable and square-wave generator. Each channel divides
// clk by a runtime-programmable value held in a shadow register. A new value
// becomes active at the channel's next wrap, immediately on sync, or on the
// next edge if the channel is disabled (divide value of zero).
module multi_clock_divider #(
  parameter int          NUM_CH  = 4,
  parameter int          CH_W    = 2,
  parameter int          CNT_W   = 25,
  parameter int unsigned DEF_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] cfg_pending
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] act_div_r;
    logic [CNT_W-1:0] shd_div_r;
    logic             pend_r;
    logic             tick_r;
    logic             clk_out_r;

    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] act_div_nxt_s;
    logic [CNT_W-1:0] shd_div_nxt_s;
    logic             pend_nxt_s;
    logic             tick_nxt_s;
    logic             clk_out_nxt_s;
    logic             wr_s;
    logic [CNT_W-1:0] act_div_m1_s;

    // Writes addressed beyond the last channel match no channel and vanish.
    assign wr_s         = cfg_we & (cfg_ch == CH_W'(i));
    // Only used after the zero-divide case is excluded, so no underflow.
    assign act_div_m1_s = act_div_r - CNT_ONE;

    // Next-state for one channel: sync > freeze > disabled > wrap > count.
    always_comb begin
      cnt_nxt_s     = cnt_r;
      act_div_nxt_s = act_div_r;
      shd_div_nxt_s = shd_div_r;
      pend_nxt_s    = pend_r;
      tick_nxt_s    = 1'b0;
      clk_out_nxt_s = clk_out_r;

      // A write lands in the shadow and raises pending; a same-cycle apply
      // below consumes the old shadow, leaving the new one pending.
      if (wr_s) begin
        shd_div_nxt_s = cfg_div;
        pend_nxt_s    = 1'b1;
      end else begin
        shd_div_nxt_s = shd_div_r;
        pend_nxt_s    = pend_r;
      end

      if (sync) begin
        cnt_nxt_s     = CNT_ZERO;
        clk_out_nxt_s = 1'b0;
        act_div_nxt_s = wr_s ? cfg_div : shd_div_r;
        pend_nxt_s    = 1'b0;
      end else if (!en) begin
        cnt_nxt_s     = cnt_r;
        act_div_nxt_s = act_div_r;
      end else if (act_div_r == CNT_ZERO) begin
        cnt_nxt_s = CNT_ZERO;
        if (pend_r) begin
          act_div_nxt_s = shd_div_r;
          pend_nxt_s    = wr_s;
        end else begin
          act_div_nxt_s = act_div_r;
        end
      end else if (cnt_r >= act_div_m1_s) begin
        // '>=' also recovers a counter left above the active divide value.
        cnt_nxt_s     = CNT_ZERO;
        tick_nxt_s    = 1'b1;
        clk_out_nxt_s = ~clk_out_r;
        if (pend_r) begin
          act_div_nxt_s = shd_div_r;
          pend_nxt_s    = wr_s;
        end else begin
          act_div_nxt_s = act_div_r;
        end
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end

    // Channel state and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_r     <= CNT_ZERO;
        act_div_r <= DIV_RST;
        shd_div_r <= DIV_RST;
        pend_r    <= 1'b0;
        tick_r    <= 1'b0;
        clk_out_r <= 1'b0;
      end else begin
        cnt_r     <= cnt_nxt_s;
        act_div_r <= act_div_nxt_s;
        shd_div_r <= shd_div_nxt_s;
        pend_r    <= pend_nxt_s;
        tick_r    <= tick_nxt_s;
        clk_out_r <= clk_out_nxt_s;
      end
    end

    assign tick[i]        = tick_r;
    assign clk_out[i]     = clk_out_r;
    assign cfg_pending[i] = pend_r;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed testbench for multi_clock_divider (NUM_CH=4, CNT_W=8, DEF_DIV=5),
// plus a NUM_CH=3 instance for out-of-range channel writes.
// Cycle c is the state just after the c-th rising edge following reset release.
module tb_multi_clock_divider;

  logic       clk;
  logic       reset;
  logic       en;
  logic       sync;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] tick;
  logic [3:0] clk_out;
  logic [3:0] cfg_pending;

  logic       cfg_we3;
  logic [1:0] cfg_ch3;
  logic [7:0] cfg_div3;
  logic [2:0] tick3;
  logic [2:0] clk_out3;
  logic [2:0] cfg_pending3;

  int n_pass  = 0;
  int n_total = 0;

  multi_clock_divider #(.NUM_CH(4), .CH_W(2), .CNT_W(8), .DEF_DIV(5)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick), .clk_out(clk_out), .cfg_pending(cfg_pending)
  );

  multi_clock_divider #(.NUM_CH(3), .CH_W(2), .CNT_W(8), .DEF_DIV(5)) dut3 (
    .clk(clk), .reset(reset), .en(en), .sync(sync),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_div(cfg_div3),
    .tick(tick3), .clk_out(clk_out3), .cfg_pending(cfg_pending3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sync     = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = 2'd0;
    cfg_div  = 8'd0;
    cfg_we3  = 1'b0;
    cfg_ch3  = 2'd0;
    cfg_div3 = 8'd0;
  endtask

  // Reset both DUTs and release just after an edge, with en=1.
  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (tick !== 4'h0) $display("FAIL rst_tick got %b exp 0000", tick); else n_pass++;
    n_total++; if (clk_out !== 4'h0) $display("FAIL rst_clk_out got %b exp 0000", clk_out); else n_pass++;
    n_total++; if (cfg_pending !== 4'h0) $display("FAIL rst_pend got %b exp 0000", cfg_pending); else n_pass++;
    n_total++; if ({tick3, clk_out3, cfg_pending3} !== 9'h0) $display("FAIL rst_dut3 got %b exp 0", {tick3, clk_out3, cfg_pending3}); else n_pass++;
  endtask

  task automatic test_default();
    logic [3:0] et;
    logic [3:0] ec;
    ec = 4'h0;
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      step();
      et = (c % 5 == 0) ? 4'hF : 4'h0;
      ec = ec ^ et;
      n_total++; if (tick !== et) $display("FAIL def_tick c=%0d got %b exp %b", c, tick, et); else n_pass++;
      n_total++; if (clk_out !== ec) $display("FAIL def_clk_out c=%0d got %b exp %b", c, clk_out, ec); else n_pass++;
      n_total++; if (cfg_pending !== 4'h0) $display("FAIL def_pend c=%0d got %b exp 0000", c, cfg_pending); else n_pass++;
      n_total++; if (tick3 !== et[2:0]) $display("FAIL def_tick3 c=%0d got %b exp %b", c, tick3, et[2:0]); else n_pass++;
    end
  endtask

  task automatic test_shadow_write();
    logic [3:0] et;
    logic [3:0] ec;
    logic [3:0] ep;
    ec = 4'h0;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step();
      et    = (c % 5 == 0) ? 4'hF : 4'h0;
      et[2] = (c == 5 || c == 10 || c == 13 || c == 16 || c == 19);
      ep    = (c == 8 || c == 9) ? 4'b0100 : 4'b0000;
      ec    = ec ^ et;
      n_total++; if (tick !== et) $display("FAIL shd_tick c=%0d got %b exp %b", c, tick, et); else n_pass++;
      n_total++; if (clk_out !== ec) $display("FAIL shd_clk_out c=%0d got %b exp %b", c, clk_out, ec); else n_pass++;
      n_total++; if (cfg_pending !== ep) $display("FAIL shd_pend c=%0d got %b exp %b", c, cfg_pending, ep); else n_pass++;
      if (c == 7) begin
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
      end else begin
        cfg_we = 1'b0;
      end
    end
  endtask

  task automatic test_disable_channel();
    logic [3:0] et;
    logic [3:0] ec;
    logic [3:0] ep;
    ec = 4'h0;
    do_reset();
    for (int c = 1; c <= 26; c++) begin
      step();
      et    = (c % 5 == 0) ? 4'hF : 4'h0;
      et[1] = (c == 5) || (c >= 18 && c % 2 == 0);
      ep    = (c == 3 || c == 4 || c == 15) ? 4'b0010 : 4'b0000;
      ec    = ec ^ et;
      n_total++; if (tick !== et) $display("FAIL dis_tick c=%0d got %b exp %b", c, tick, et); else n_pass++;
      n_total++; if (clk_out !== ec) $display("FAIL dis_clk_out c=%0d got %b exp %b", c, clk_out, ec); else n_pass++;
      n_total++; if (cfg_pending !== ep) $display("FAIL dis_pend c=%0d got %b exp %b", c, cfg_pending, ep); else n_pass++;
      if (c == 2) begin
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
      end else if (c == 14) begin
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2;
      end else begin
        cfg_we = 1'b0;
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [3:0] et;
    logic [3:0] ec;
    ec = 4'h0;
    do_reset();
    for (int c = 1; c <= 28; c++) begin
      step();
      et = (c == 5 || c == 17 || c == 22 || c == 27) ? 4'hF : 4'h0;
      ec = ec ^ et;
      n_total++; if (tick !== et) $display("FAIL en_tick c=%0d got %b exp %b", c, tick, et); else n_pass++;
      n_total++; if (clk_out !== ec) $display("FAIL en_clk_out c=%0d got %b exp %b", c, clk_out, ec); else n_pass++;
      if (c == 7) en = 1'b0;
      else if (c == 14) en = 1'b1;
      else en = en;
    end
  endtask

  task automatic test_sync_write();
    logic [3:0] et;
    logic [3:0] ec;
    ec = 4'h0;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step();
      et    = (c == 5 || (c >= 13 && (c - 8) % 5 == 0)) ? 4'hF : 4'h0;
      et[0] = (c == 5) || (c >= 12 && (c - 8) % 4 == 0);
      if (c == 8) ec = 4'h0;
      else ec = ec ^ et;
      n_total++; if (tick !== et) $display("FAIL sync_tick c=%0d got %b exp %b", c, tick, et); else n_pass++;
      n_total++; if (clk_out !== ec) $display("FAIL sync_clk_out c=%0d got %b exp %b", c, clk_out, ec); else n_pass++;
      n_total++; if (cfg_pending !== 4'h0) $display("FAIL sync_pend c=%0d got %b exp 0000", c, cfg_pending); else n_pass++;
      if (c == 7) begin
        sync = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
      end else begin
        sync = 1'b0; cfg_we = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] et;
    logic [3:0] ec;
    ec = 4'h0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 6) begin
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
      end else begin
        cfg_we = 1'b0;
      end
    end
    n_total++; if (clk_out !== 4'hF) $display("FAIL mid_pre_clk_out got %b exp 1111", clk_out); else n_pass++;
    n_total++; if (cfg_pending !== 4'b1000) $display("FAIL mid_pre_pend got %b exp 1000", cfg_pending); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++; if (clk_out !== 4'h0) $display("FAIL mid_async_clk_out got %b exp 0000", clk_out); else n_pass++;
    n_total++; if (cfg_pending !== 4'h0) $display("FAIL mid_async_pend got %b exp 0000", cfg_pending); else n_pass++;
    n_total++; if (clk_out3 !== 3'h0) $display("FAIL mid_async_clk_out3 got %b exp 000", clk_out3); else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      step();
      et = (c == 5 || c == 10) ? 4'hF : 4'h0;
      ec = ec ^ et;
      n_total++; if (tick !== et) $display("FAIL mid_tick c=%0d got %b exp %b", c, tick, et); else n_pass++;
      n_total++; if (clk_out !== ec) $display("FAIL mid_clk_out c=%0d got %b exp %b", c, clk_out, ec); else n_pass++;
      n_total++; if (cfg_pending !== 4'h0) $display("FAIL mid_pend c=%0d got %b exp 0000", c, cfg_pending); else n_pass++;
    end
  endtask

  task automatic test_div_one();
    logic [3:0] et;
    logic [3:0] ec;
    logic [3:0] ep;
    ec = 4'h0;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      step();
      et    = (c % 5 == 0) ? 4'hF : 4'h0;
      et[0] = (c >= 5);
      ep    = (c >= 2 && c <= 4) ? 4'b0001 : 4'b0000;
      ec    = ec ^ et;
      n_total++; if (tick !== et) $display("FAIL div1_tick c=%0d got %b exp %b", c, tick, et); else n_pass++;
      n_total++; if (clk_out !== ec) $display("FAIL div1_clk_out c=%0d got %b exp %b", c, clk_out, ec); else n_pass++;
      n_total++; if (cfg_pending !== ep) $display("FAIL div1_pend c=%0d got %b exp %b", c, cfg_pending, ep); else n_pass++;
      if (c == 1) begin
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
      end else begin
        cfg_we = 1'b0;
      end
    end
  endtask

  task automatic test_ignored_write();
    logic [2:0] et;
    logic [2:0] ec;
    ec = 3'h0;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      et = (c % 5 == 0) ? 3'b111 : 3'b000;
      ec = ec ^ et;
      n_total++; if (tick3 !== et) $display("FAIL ign_tick3 c=%0d got %b exp %b", c, tick3, et); else n_pass++;
      n_total++; if (clk_out3 !== ec) $display("FAIL ign_clk_out3 c=%0d got %b exp %b", c, clk_out3, ec); else n_pass++;
      n_total++; if (cfg_pending3 !== 3'h0) $display("FAIL ign_pend3 c=%0d got %b exp 000", c, cfg_pending3); else n_pass++;
      if (c == 2) begin
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd1;
      end else begin
        cfg_we3 = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    idle_inputs();
    test_reset();
    test_default();
    test_shadow_write();
    test_disable_channel();
    test_enable_hold();
    test_sync_write();
    test_reset_mid_count();
    test_div_one();
    test_ignored_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
